// File: rtl/counter_event_logger.sv
// Epoch extender and event-record logger for a small wrapping counter.
// Wrap and sample events become {type, epoch, cnt} records in a FWFT FIFO; overflowing records are dropped and counted.
module counter_event_logger #(
  parameter int CW    = 4,
  parameter int EW    = 12,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CW-1:0]          count,
  input  logic                   overflow,
  input  logic                   sample,
  output logic                   rec_valid,
  output logic [EW+CW:0]         rec_data,
  input  logic                   rec_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             drop_cnt,
  output logic [EW-1:0]          epoch
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = 1 + EW + CW;
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [EW-1:0] epoch_reg, epoch_next;
  logic          pend_valid_reg, pend_valid_next;
  logic [RW-1:0] pend_data_reg, pend_data_next;
  logic [AW:0]   wr_ptr_reg, wr_ptr_next;
  logic [AW:0]   rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   level_reg, level_next;
  logic [7:0]    drop_reg, drop_next;
  logic [RW-1:0] mem [DEPTH];

  logic [RW-1:0] wrap_rec, samp_rec, push_data;
  logic          push, pend_drop, fifo_drop, pop, full, wr_en;
  logic [8:0]    drop_sum;

  assign wrap_rec = {1'b0, epoch_reg + EW'(1), {CW{1'b0}}};
  assign samp_rec = {1'b1, epoch_reg, count};

  // Single push slot: wrap beats a deferred sample, which beats a fresh sample.
  always_comb begin
    push            = 1'b0;
    push_data       = wrap_rec;
    pend_valid_next = pend_valid_reg;
    pend_data_next  = pend_data_reg;
    pend_drop       = 1'b0;
    if (overflow) begin
      push = 1'b1;
      if (sample) begin
        pend_valid_next = 1'b1;
        pend_data_next  = samp_rec;
        pend_drop       = pend_valid_reg;
      end
    end else if (pend_valid_reg) begin
      push            = 1'b1;
      push_data       = pend_data_reg;
      pend_valid_next = sample;
      pend_data_next  = samp_rec;
    end else if (sample) begin
      push      = 1'b1;
      push_data = samp_rec;
    end
  end

  assign full      = (level_reg == FULL_LEVEL);
  assign pop       = (level_reg != '0) && rec_ready;
  assign wr_en     = push && (!full || pop);
  assign fifo_drop = push && full && !pop;

  always_comb begin
    wr_ptr_next = wr_en ? wr_ptr_reg + PTR_ONE : wr_ptr_reg;
    rd_ptr_next = pop ? rd_ptr_reg + PTR_ONE : rd_ptr_reg;
    level_next  = level_reg;
    if (wr_en && !pop) begin
      level_next = level_reg + PTR_ONE;
    end else if (pop && !wr_en) begin
      level_next = level_reg - PTR_ONE;
    end
  end

  // A pending overwrite and a FIFO overflow can both drop in one cycle.
  always_comb begin
    drop_sum  = {1'b0, drop_reg} + 9'(pend_drop) + 9'(fifo_drop);
    drop_next = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end

  assign epoch_next = overflow ? epoch_reg + EW'(1) : epoch_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      epoch_reg      <= '0;
      pend_valid_reg <= 1'b0;
      pend_data_reg  <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      drop_reg       <= '0;
    end else begin
      epoch_reg      <= epoch_next;
      pend_valid_reg <= pend_valid_next;
      pend_data_reg  <= pend_data_next;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      level_reg      <= level_next;
      drop_reg       <= drop_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  // Head is masked while empty so stale storage never leaks out after reset.
  assign rec_valid = (level_reg != '0);
  assign rec_data  = rec_valid ? mem[rd_ptr_reg[AW-1:0]] : '0;
  assign level     = level_reg;
  assign drop_cnt  = drop_reg;
  assign epoch     = epoch_reg;

endmodule

// File: tb/tb_counter_event_logger.sv
// Directed bench for counter_event_logger: wraps, samples, deferral, FIFO full/drop, epoch wrap, reset.
module tb_counter_event_logger;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  count;
  logic        overflow;
  logic        sample;
  logic        rec_valid;
  logic [16:0] rec_data;
  logic        rec_ready;
  logic [3:0]  level;
  logic [7:0]  drop_cnt;
  logic [11:0] epoch;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  counter_event_logger #(.CW(4), .EW(12), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .count(count), .overflow(overflow), .sample(sample),
    .rec_valid(rec_valid), .rec_data(rec_data), .rec_ready(rec_ready),
    .level(level), .drop_cnt(drop_cnt), .epoch(epoch)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic t, input logic [11:0] e, input logic [3:0] c);
    return {15'd0, t, e, c};
  endfunction

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(rec_valid), 32'd0);
    check({tag, "_level"}, 32'(level), 32'd0);
    check({tag, "_drop"}, 32'(drop_cnt), 32'd0);
    check({tag, "_epoch"}, 32'(epoch), 32'd0);
    check({tag, "_data"}, 32'(rec_data), 32'd0);
  endtask

  initial begin
    logic [3:0] exp_cnt [8];
    rst = 1'b1; count = '0; overflow = 1'b0; sample = 1'b0; rec_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_zero("reset");

    // Three wraps 16 cycles apart with an always-ready consumer
    for (int k = 1; k <= 3; k++) begin
      overflow = 1'b1;
      step();
      overflow = 1'b0;
      check($sformatf("wrap%0d_valid", k), 32'(rec_valid), 32'd1);
      check($sformatf("wrap%0d_data", k), 32'(rec_data), mk(1'b0, 12'(k), 4'd0));
      check($sformatf("wrap%0d_epoch", k), 32'(epoch), 32'(k));
      repeat (15) step();
      check($sformatf("wrap%0d_drain", k), 32'(level), 32'd0);
    end
    $display("wraps done epoch=%0d", epoch);

    // Advance epoch to 5, then a lone sample with count=9
    overflow = 1'b1;
    step();
    step();
    overflow = 1'b0;
    repeat (3) step();
    check("epoch5", 32'(epoch), 32'd5);
    rec_ready = 1'b0; count = 4'd9; sample = 1'b1;
    step();
    sample = 1'b0;
    check("samp_valid", 32'(rec_valid), 32'd1);
    check("samp_data", 32'(rec_data), mk(1'b1, 12'd5, 4'd9));
    check("samp_level", 32'(level), 32'd1);
    step();
    check("samp_hold_level", 32'(level), 32'd1);
    check("samp_hold_data", 32'(rec_data), mk(1'b1, 12'd5, 4'd9));
    rec_ready = 1'b1;
    step();
    check("samp_pop", 32'(level), 32'd0);
    $display("sample record done");

    // Epoch to 7, then overflow and sample together
    overflow = 1'b1;
    step();
    step();
    overflow = 1'b0;
    repeat (3) step();
    rec_ready = 1'b0; count = 4'd15; overflow = 1'b1; sample = 1'b1;
    step();
    overflow = 1'b0; sample = 1'b0;
    check("both_n1_data", 32'(rec_data), mk(1'b0, 12'd8, 4'd0));
    check("both_n1_level", 32'(level), 32'd1);
    check("both_epoch", 32'(epoch), 32'd8);
    step();
    check("both_n2_level", 32'(level), 32'd2);
    rec_ready = 1'b1;
    step();
    check("both_second", 32'(rec_data), mk(1'b1, 12'd7, 4'd15));
    step();
    check("both_empty", 32'(level), 32'd0);
    $display("deferred sample done");

    // Ten pushes into a stalled FIFO of depth 8
    rec_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      count = 4'(i); sample = 1'b1;
      step();
    end
    sample = 1'b0;
    check("full_level", 32'(level), 32'd8);
    check("full_drop", 32'(drop_cnt), 32'd2);
    check("full_head", 32'(rec_data), mk(1'b1, 12'd8, 4'd0));
    rec_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d", i), 32'(rec_data), mk(1'b1, 12'd8, 4'(i)));
      step();
    end
    check("drain_valid", 32'(rec_valid), 32'd0);
    $display("full and drain done");

    // Full FIFO: push and pop in the same cycle
    rec_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      count = 4'(i); sample = 1'b1;
      step();
    end
    rec_ready = 1'b1; count = 4'd10; sample = 1'b1;
    step();
    sample = 1'b0; rec_ready = 1'b0;
    check("pp_level", 32'(level), 32'd8);
    check("pp_drop", 32'(drop_cnt), 32'd2);
    check("pp_head", 32'(rec_data), mk(1'b1, 12'd8, 4'd1));
    exp_cnt = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10};
    rec_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("pp_drain%0d", i), 32'(rec_data), mk(1'b1, 12'd8, exp_cnt[i]));
      step();
    end
    $display("push/pop at full done");

    // Saturating drop counter: 8 fills then 300 drops
    rec_ready = 1'b0; sample = 1'b1; count = 4'd2;
    repeat (308) step();
    sample = 1'b0;
    check("sat_drop", 32'(drop_cnt), 32'd255);
    check("sat_level", 32'(level), 32'd8);
    rec_ready = 1'b1;
    repeat (8) step();
    check("sat_empty", 32'(level), 32'd0);

    // Epoch wrap: drive epoch from 8 to 4095, then one more overflow
    overflow = 1'b1;
    repeat (4087) step();
    check("epoch_max", 32'(epoch), 32'd4095);
    check("epoch_max_rec", 32'(rec_data), mk(1'b0, 12'd4095, 4'd0));
    step();
    overflow = 1'b0;
    check("ewrap_epoch", 32'(epoch), 32'd0);
    check("ewrap_valid", 32'(rec_valid), 32'd1);
    check("ewrap_data", 32'(rec_data), mk(1'b0, 12'd0, 4'd0));
    rec_ready = 1'b0; sample = 1'b1; count = 4'd3;
    repeat (3) step();
    sample = 1'b0;
    check("pre_rst_level", 32'(level), 32'd4);
    rst = 1'b1;
    step();
    check_zero("midrst");
    rst = 1'b0;
    $display("epoch wrap and reset done");

    // Pending overwrite: two overflow+sample cycles back to back
    count = 4'd5; overflow = 1'b1; sample = 1'b1;
    step();
    check("pend_a_level", 32'(level), 32'd1);
    count = 4'd6;
    step();
    overflow = 1'b0; sample = 1'b0;
    check("pend_b_level", 32'(level), 32'd2);
    check("pend_b_drop", 32'(drop_cnt), 32'd1);
    step();
    check("pend_c_level", 32'(level), 32'd3);
    rec_ready = 1'b1;
    check("pend_r0", 32'(rec_data), mk(1'b0, 12'd1, 4'd0));
    step();
    check("pend_r1", 32'(rec_data), mk(1'b0, 12'd2, 4'd0));
    step();
    check("pend_r2", 32'(rec_data), mk(1'b1, 12'd1, 4'd6));
    step();
    check("pend_empty", 32'(rec_valid), 32'd0);
    $display("pending overwrite done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
